// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift/add multiply, restoring divide.
// Define MULDIV_MUL_FAST_EN to replace the iterative multiplier with a one-cycle 33x33 multiply.
module muldiv_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int unsigned CW = 6;
  localparam int unsigned PW = 2 * XLEN;
  localparam logic [CW-1:0]   LAST    = CW'(31);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]   cnt_q;
  logic [1:0]      f3_q;
  logic            neg_q, neg_r_q;
  logic [XLEN-1:0] opnd_q, hi_q, lo_q;

  logic            signed_a, signed_b, neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf, fast_div, accept;
  logic [XLEN-1:0] fast_res;

  logic [XLEN:0]   mul_sum, div_sh;
  logic [XLEN-1:0] div_diff;
  logic            div_ge;
  logic [XLEN-1:0] iter_hi, iter_lo;
  logic [PW-1:0]   prod, prod_s;
  logic [XLEN-1:0] quo, rem_v, mul_res, div_res;

  // Operand signedness, magnitudes and the divide fast path
  always_comb begin
    signed_a = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    signed_b = funct3[2] ? ~funct3[0] : ~funct3[1];
    neg_a    = signed_a & op_a[XLEN-1];
    neg_b    = signed_b & op_b[XLEN-1];
    mag_a    = neg_a ? -op_a : op_a;
    mag_b    = neg_b ? -op_b : op_b;
    div_zero = (op_b == '0);
    div_ovf  = ~funct3[0] & (op_a == MIN_NEG) & (op_b == '1);
    fast_div = funct3[2] & (div_zero | div_ovf);
    if (div_zero) fast_res = funct3[1] ? op_a : '1;
    else          fast_res = funct3[1] ? '0 : MIN_NEG;
    accept   = (state == S_IDLE) & start & ~flush;
  end

`ifdef MULDIV_MUL_FAST_EN
  logic signed [XLEN:0] ext_a, ext_b;
  logic [PW-1:0]        fast_prod;
  logic [XLEN-1:0]      fast_mul_res;

  always_comb begin
    ext_a        = {signed_a & op_a[XLEN-1], op_a};
    ext_b        = {signed_b & op_b[XLEN-1], op_b};
    fast_prod    = PW'(ext_a * ext_b);
    fast_mul_res = (funct3[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[PW-1:XLEN];
  end
`endif

  // One iteration step; hi_q is the running sum/remainder, lo_q the multiplier/quotient
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_sh   = {hi_q, lo_q[XLEN-1]};
    div_ge   = (div_sh >= {1'b0, opnd_q});
    div_diff = div_sh[XLEN-1:0] - opnd_q;
    if (state == S_MUL) begin
      iter_hi = mul_sum[XLEN:1];
      iter_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end else begin
      iter_hi = div_ge ? div_diff : div_sh[XLEN-1:0];
      iter_lo = {lo_q[XLEN-2:0], div_ge};
    end
    prod    = {iter_hi, iter_lo};
    prod_s  = neg_q ? -prod : prod;
    mul_res = (f3_q == 2'b00) ? prod_s[XLEN-1:0] : prod_s[PW-1:XLEN];
    quo     = neg_q ? -iter_lo : iter_lo;
    rem_v   = neg_r_q ? -iter_hi : iter_hi;
    div_res = f3_q[1] ? rem_v : quo;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start) begin
`ifdef MULDIV_MUL_FAST_EN
          if (funct3[2]) state_nxt = fast_div ? S_DONE : S_DIV;
          else           state_nxt = S_DONE;
`else
          if (funct3[2]) state_nxt = fast_div ? S_DONE : S_DIV;
          else           state_nxt = S_MUL;
`endif
        end
        S_MUL, S_DIV: if (cnt_q == LAST) state_nxt = S_DONE;
        S_DONE: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // stall is combinational so EX holds the op from the very cycle it appears
  always_comb begin
    stall = ~rst & (((state == S_IDLE) & start & ~flush) | (state == S_MUL) | (state == S_DIV));
    busy  = (state != S_IDLE);
    done  = (state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      f3_q    <= '0;
      neg_q   <= 1'b0;
      neg_r_q <= 1'b0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (accept) begin
      cnt_q   <= '0;
      f3_q    <= funct3[1:0];
      neg_q   <= neg_a ^ neg_b;
      neg_r_q <= neg_a;
      hi_q    <= '0;
      opnd_q  <= funct3[2] ? mag_b : mag_a;
      lo_q    <= funct3[2] ? mag_a : mag_b;
    end else if (state == S_MUL || state == S_DIV) begin
      hi_q  <= iter_hi;
      lo_q  <= iter_lo;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
    end else if (accept && fast_div) begin
      result <= fast_res;
`ifdef MULDIV_MUL_FAST_EN
    end else if (accept && !funct3[2]) begin
      result <= fast_mul_res;
`endif
    end else if (!flush && (state == S_MUL || state == S_DIV) && cnt_q == LAST) begin
      result <= (state == S_MUL) ? mul_res : div_res;
    end
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative RV32M multiply/divide sequencer for the execute stage of the pipelined core. It accepts one M-extension operation from EX and stalls the pipeline while a radix-2 shift/add or shift/subtract datapath iterates. It then presents a 32-bit result for one cycle, so the EX/MEM register captures it and writeback reaches the register file normally. Divide-by-zero and signed overflow use a fast path.

## Interface
- XLEN, 32, operand/result width; only 32 supported.
- clk  input  1  core clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  EX holds a valid M-op this cycle (opcode 0110011, funct7 0000001).
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  XLEN  rs1 value (forwarded).
- op_b  input  XLEN  rs2 value (forwarded).
- flush  input  1  branch/jump kill of the EX instruction.
- stall  output  1  freeze PC, IF/ID and ID/EX.
- busy  output  1  state is not IDLE.
- done  output  1  result valid; one-cycle pulse.
- result  output  XLEN  operation result, held until the next done.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE, start=1, flush=0:
  - Latch funct3 and the operand magnitudes/signs.
  - Clear the 6-bit counter.
  - funct3[2]=0 goes to MUL. funct3[2]=1 goes to DIV, except on the fast path, which goes to DONE.
- Fast path:
  - op_b==0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give op_a.
  - Signed DIV/REM with op_a=0x80000000, op_b=0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- MUL: 64-bit shift-add on unsigned magnitudes, one multiplier bit per cycle, 32 iterations. Negate the product when the operand signs differ; signedness follows funct3 (MULHSU: op_a signed, op_b unsigned).
  - MUL returns product[31:0].
  - MULH, MULHSU and MULHU return product[63:32].
- DIV: restoring division on magnitudes, 32 iterations. Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a). DIVU/REMU use no sign handling.
- After 32 iterations (counter==31 at the edge), go to DONE and register result.
- DONE: done=1. Return to IDLE next edge. A start in the DONE cycle is ignored; the pipeline advances, so the next op is presented in a later cycle.
- start while in MUL or DIV is ignored; the ID/EX stage is frozen, so start stays high until done.
- flush=1 in any state forces IDLE at the next edge. No done is produced and result is unchanged. flush has priority over start.
- stall = (state==IDLE & start & ~flush) | state==MUL | state==DIV. It is combinational, so the instruction never leaves EX before done.

## Timing
- Reset values: state IDLE, counter 0, stall 0, busy 0, done 0, result 0x00000000.
- start sampled at edge k:
  - Iterative op: done high between edges k+33 and k+34.
  - Fast path: done high between edges k+1 and k+2.
- stall is low in the DONE cycle.
- busy is high from edge k+1 through the DONE cycle.
- Reset asserted mid-operation returns to IDLE immediately; result is cleared.
- Back-to-back ops: the second start is accepted no earlier than the cycle after DONE.

## Configuration
- MULDIV_MUL_FAST_EN defined:
  - MUL, MULH, MULHSU and MULHU compute in one cycle through a combinational 33x33 signed multiplier.
  - IDLE goes straight to DONE, giving fast-path latency (done after edge k+1).
  - State MUL is unused.
- Undefined: the iterative 32-cycle multiplier described above is used; no hardware multiplier is inferred.
- Divide behaviour is identical in both builds.

## Test plan
- Reset mid-DIV: assert rst 10 cycles after start. Required: done never pulses, result=0, stall=0 immediately.
- MUL a=0xFFFFFFFE (-2), b=3:
  - result 0xFFFFFFFA.
  - MULH result 0xFFFFFFFF, MULHU result 0x00000002.
  - done exactly 33 cycles after start (1 cycle with MULDIV_MUL_FAST_EN).
  - stall high 33 cycles.
- DIV a=-7 (0xFFFFFFF9), b=2: quotient 0xFFFFFFFD. REM gives 0xFFFFFFFF. DIVU gives 0x7FFFFFFC.
- Corner cases, each with done one cycle after start:
  - DIVU 5/0 gives 0xFFFFFFFF.
  - REMU 5/0 gives 5.
  - DIV 0x80000000/0xFFFFFFFF gives 0x80000000.
  - REM of the same operands gives 0.
- flush asserted 5 cycles into a MULHU: next cycle state=IDLE and stall=0; done never pulses; result keeps its prior value.
- Two consecutive DIVs (100/7 then 100%7): results 14 then 2. The second start is accepted the cycle after the first DONE.
